// File: rtl/axi_dcache_slave.sv
// AXI4 slave backed by a word-addressed local memory, with independent read and write burst engines.
// Optional build macro AXI_SLAVE_RAND_STALL_EN gates rvalid/wready with a free-running 16-bit LFSR.
module axi_dcache_slave #(
  parameter int ID_WIDTH     = 4,
  parameter int MEM_WORDS    = 4096,
  parameter int READ_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_WIDTH-1:0] arid,
  input  logic [31:0]         araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_WIDTH-1:0] rid,
  output logic [31:0]         rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ID_WIDTH-1:0] awid,
  input  logic [31:0]         awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [31:0]         wdata,
  input  logic [3:0]          wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_WIDTH-1:0] bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);
  localparam int         IDX_W       = $clog2(MEM_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] RWAIT_LAST  = 3'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } burst_t;

  function automatic logic [31:0] step_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [1:0] burst);
    return (burst == 2'b00) ? addr : addr + (32'd1 << size);
  endfunction

  logic [31:0] mem [MEM_WORDS];

  r_state_e            r_state_q, r_state_d;
  burst_t              r_ctx_q, r_ctx_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  logic [7:0]          rbeat_q, rbeat_d;
  logic [2:0]          rwait_q, rwait_d;
  logic [31:0]         rdata_q, rdata_d;
  w_state_e            w_state_q, w_state_d;
  burst_t              w_ctx_q, w_ctx_d;
  logic [ID_WIDTH-1:0] wid_q, wid_d;
  logic [7:0]          wbeat_q, wbeat_d;
  logic                werr_q, werr_d;
  logic                en_q, en_d;
  logic                r_fire, w_fire;
  logic [31:0]         r_next_addr, w_next_addr;

`ifdef AXI_SLAVE_RAND_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        rhold_q, rhold_d;
  assign lfsr_d  = {lfsr_q[0], lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign rvalid  = (r_state_q == R_BURST) && (!lfsr_q[0] || rhold_q);
  assign wready  = (w_state_q == W_DATA) && !lfsr_q[1];
  assign rhold_d = rvalid && !rready;
`else
  assign rvalid  = (r_state_q == R_BURST);
  assign wready  = (w_state_q == W_DATA);
`endif

  // Ready outputs wait one clock after reset release so they are low throughout reset.
  assign en_d        = 1'b1;
  assign arready     = (r_state_q == R_IDLE) && en_q;
  assign awready     = (w_state_q == W_IDLE) && en_q;
  assign r_fire      = rvalid && rready;
  assign w_fire      = wvalid && wready;
  assign r_next_addr = step_addr(r_ctx_q.addr, r_ctx_q.size, r_ctx_q.burst);
  assign w_next_addr = step_addr(w_ctx_q.addr, w_ctx_q.size, w_ctx_q.burst);

  assign rid    = rid_q;
  assign rdata  = rdata_q;
  assign rlast  = (r_state_q == R_BURST) && (rbeat_q == r_ctx_q.len);
  assign rresp  = ((r_state_q == R_BURST) && r_ctx_q.burst[1]) ? RESP_SLVERR : RESP_OKAY;
  assign bid    = wid_q;
  assign bvalid = (w_state_q == W_RESP);
  assign bresp  = ((w_state_q == W_RESP) && werr_q) ? RESP_SLVERR : RESP_OKAY;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    r_state_d = r_state_q;
    r_ctx_d   = r_ctx_q;
    rid_d     = rid_q;
    rbeat_d   = rbeat_q;
    rwait_d   = rwait_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      R_IDLE: if (arvalid && arready) begin
        rid_d   = arid;
        r_ctx_d = '{addr: araddr, len: arlen, size: arsize, burst: arburst};
        rbeat_d = '0;
        rwait_d = '0;
        if (READ_LATENCY == 1) begin
          r_state_d = R_BURST;
          rdata_d   = mem[araddr[IDX_W+1:2]];
        end else begin
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: if (rwait_q == RWAIT_LAST) begin
        r_state_d = R_BURST;
        rdata_d   = mem[r_ctx_q.addr[IDX_W+1:2]];
      end else begin
        rwait_d = rwait_q + 3'd1;
      end
      R_BURST: if (r_fire) begin
        if (rbeat_q == r_ctx_q.len) begin
          r_state_d = R_IDLE;
        end else begin
          r_ctx_d.addr = r_next_addr;
          rbeat_d      = rbeat_q + 8'd1;
          rdata_d      = mem[r_next_addr[IDX_W+1:2]];
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    w_ctx_d   = w_ctx_q;
    wid_d     = wid_q;
    wbeat_d   = wbeat_q;
    werr_d    = werr_q;
    unique case (w_state_q)
      W_IDLE: if (awvalid && awready) begin
        wid_d     = awid;
        w_ctx_d   = '{addr: awaddr, len: awlen, size: awsize, burst: awburst};
        wbeat_d   = '0;
        werr_d    = awburst[1];
        w_state_d = W_DATA;
      end
      W_DATA: if (w_fire) begin
        if (wlast != (wbeat_q == w_ctx_q.len)) werr_d = 1'b1;
        if (wbeat_q == w_ctx_q.len) begin
          w_state_d = W_RESP;
        end else begin
          w_ctx_d.addr = w_next_addr;
          wbeat_d      = wbeat_q + 8'd1;
        end
      end
      W_RESP: if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      r_ctx_q   <= '0;
      rid_q     <= '0;
      rbeat_q   <= '0;
      rwait_q   <= '0;
      rdata_q   <= '0;
      w_state_q <= W_IDLE;
      w_ctx_q   <= '0;
      wid_q     <= '0;
      wbeat_q   <= '0;
      werr_q    <= 1'b0;
      en_q      <= 1'b0;
`ifdef AXI_SLAVE_RAND_STALL_EN
      lfsr_q    <= 16'hACE1;
      rhold_q   <= 1'b0;
`endif
    end else begin
      r_state_q <= r_state_d;
      r_ctx_q   <= r_ctx_d;
      rid_q     <= rid_d;
      rbeat_q   <= rbeat_d;
      rwait_q   <= rwait_d;
      rdata_q   <= rdata_d;
      w_state_q <= w_state_d;
      w_ctx_q   <= w_ctx_d;
      wid_q     <= wid_d;
      wbeat_q   <= wbeat_d;
      werr_q    <= werr_d;
      en_q      <= en_d;
`ifdef AXI_SLAVE_RAND_STALL_EN
      lfsr_q    <= lfsr_d;
      rhold_q   <= rhold_d;
`endif
    end
  end

  // NOTE: the memory array has no reset; committed bytes survive a reset.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[w_ctx_q.addr[IDX_W+1:2]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_dcache_slave.sv
// Self-checking bench for axi_dcache_slave: directed scenarios plus randomized bursts,
// scored against a word-array reference model through R and B expectation queues.
module tb_axi_dcache_slave;
  localparam int ID_W      = 4;
  localparam int MEM_WORDS = 4096;
  localparam int RL        = 2;

  typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [ID_W-1:0] id; } r_exp_t;
  typedef struct { logic [1:0] resp; logic [ID_W-1:0] id; } b_exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [ID_W-1:0] arid, rid, awid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  axi_dcache_slave #(.ID_WIDTH(ID_W), .MEM_WORDS(MEM_WORDS), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int r_pops = 0;
  int rready_mode = 0;  // 0: always ready, 1: random, 2: held low
  logic [31:0] model_mem [MEM_WORDS];
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];
  r_exp_t rq[$];
  b_exp_t bq[$];
  r_exp_t r_e;
  b_exp_t b_e;
  logic r_hold = 1'b0;
  logic [31:0] h_data;
  logic [1:0]  h_resp;
  logic        h_last;
  logic [ID_W-1:0] h_id;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % MEM_WORDS);
  endfunction

  task automatic wait_hs(input int ch, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if ((ch == 0 && arready) || (ch == 1 && awready) || (ch == 2 && wready)) ok = 1'b1;
    end
    if (ok) begin @(posedge clk); #1; end
  endtask

  task automatic ar_issue(input logic [31:0] addr, input int len, input int size,
                          input int burst, input int id);
    logic [31:0] a = addr;
    bit ok;
    r_exp_t e;
    for (int i = 0; i <= len; i++) begin
      e.data = model_mem[widx(a)];
      e.resp = (burst >= 2) ? 2'b10 : 2'b00;
      e.last = (i == len);
      e.id   = ID_W'(id);
      rq.push_back(e);
      if (burst != 0) a = a + (32'd1 << size);
    end
    arid = ID_W'(id); araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
    arvalid = 1'b1;
    wait_hs(0, ok);
    check("ar_handshake", 32'(ok), 1);
    arvalid = 1'b0;
  endtask

  task automatic check_latency();
    int n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 20);
    check("r_first_latency", n, RL);
  endtask

  task automatic aw_issue(input logic [31:0] addr, input int len, input int size,
                          input int burst, input int id, input int bad);
    bit ok;
    b_exp_t e;
    e.resp = (burst >= 2 || bad >= 0) ? 2'b10 : 2'b00;
    e.id   = ID_W'(id);
    bq.push_back(e);
    awid = ID_W'(id); awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1'b1;
    wait_hs(1, ok);
    check("aw_handshake", 32'(ok), 1);
    awvalid = 1'b0;
  endtask

  task automatic w_beats(input logic [31:0] addr, input int len, input int size,
                         input int burst, input int bad);
    logic [31:0] a = addr;
    bit ok;
    for (int i = 0; i <= len; i++) begin
      for (int b = 0; b < 4; b++)
        if (sbuf[i][b]) model_mem[widx(a)][8*b +: 8] = wbuf[i][8*b +: 8];
      wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == len) ^ (i == bad);
      wvalid = 1'b1;
      wait_hs(2, ok);
      check("w_handshake", 32'(ok), 1);
      if (burst != 0) a = a + (32'd1 << size);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic r_wait();
    for (int t = 0; t < 2000 && rq.size() != 0; t++) @(posedge clk);
    check("r_drain", rq.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic b_wait();
    for (int t = 0; t < 2000 && bq.size() != 0; t++) @(posedge clk);
    check("b_drain", bq.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input int size,
                          input int burst, input int id, input int bad);
    aw_issue(addr, len, size, burst, id, bad);
    w_beats(addr, len, size, burst, bad);
    b_wait();
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input int size,
                         input int burst, input int id);
    ar_issue(addr, len, size, burst, id);
    check_latency();
    r_wait();
  endtask

  // Ready generators for the response channels.
  initial begin
    rready = 1'b1;
    bready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rready = (rready_mode == 2) ? 1'b0 : (rready_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      bready = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: scores every R and B handshake and the hold rule on stalled beats.
  always @(negedge clk) begin
    if (!rst) begin
      r_hold = 1'b0;
    end else begin
      if (r_hold) begin
        check("r_hold_valid", 32'(rvalid), 1);
        check("r_hold_data", rdata, h_data);
        check("r_hold_resp", 32'(rresp), 32'(h_resp));
        check("r_hold_last", 32'(rlast), 32'(h_last));
        check("r_hold_id", 32'(rid), 32'(h_id));
      end
      r_hold = rvalid && !rready;
      h_data = rdata; h_resp = rresp; h_last = rlast; h_id = rid;
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          check("r_unexpected_beat", 32'(rvalid), 0);
        end else begin
          r_e = rq.pop_front();
          check("r_data", rdata, r_e.data);
          check("r_resp", 32'(rresp), 32'(r_e.resp));
          check("r_last", 32'(rlast), 32'(r_e.last));
          check("r_id", 32'(rid), 32'(r_e.id));
          r_pops++;
        end
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          check("b_unexpected", 32'(bvalid), 0);
        end else begin
          b_e = bq.pop_front();
          check("b_resp", 32'(bresp), 32'(b_e.resp));
          check("b_id", 32'(bid), 32'(b_e.id));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual still running, required finish");
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1'b0;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    wdata = '0; wstrb = '0;
    #12;
    check("rst_arready", 32'(arready), 0);
    check("rst_awready", 32'(awready), 0);
    check("rst_wready", 32'(wready), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_bvalid", 32'(bvalid), 0);
    check("rst_rlast", 32'(rlast), 0);
    check("rst_rdata", rdata, 0);
    check("rst_resps", {28'd0, rresp, bresp}, 0);
    check("rst_ids", {24'd0, rid, bid}, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("post_rst_arready", 32'(arready), 1);
    check("post_rst_awready", 32'(awready), 1);
    @(posedge clk); #1;

    // INCR burst write then read back.
    wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222; wbuf[2] = 32'h33333333; wbuf[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) sbuf[i] = 4'hF;
    do_write(32'h100, 3, 2, 1, 3, -1);
    do_read(32'h100, 3, 2, 1, 5);

    // Byte strobe merge.
    wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'hF;
    do_write(32'h200, 0, 2, 1, 1, -1);
    wbuf[0] = 32'h000000EE; sbuf[0] = 4'b0001;
    do_write(32'h200, 0, 2, 1, 2, -1);
    do_read(32'h200, 0, 2, 1, 4);

    // rready low for 3 cycles on beat 1.
    base = r_pops;
    ar_issue(32'h100, 3, 2, 1, 6);
    for (int t = 0; t < 100 && r_pops < base + 1; t++) @(posedge clk);
    rready_mode = 2;
    repeat (3) @(posedge clk);
    rready_mode = 0;
    r_wait();

    // Error responses: early wlast, then WRAP read.
    wbuf[0] = 32'hCAFE0001; wbuf[1] = 32'hCAFE0002; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    do_write(32'h300, 1, 2, 1, 7, 0);
    do_read(32'h100, 3, 2, 2, 8);

    // Read and write of the same word in the same cycle return the old data.
    wbuf[0] = 32'h0; sbuf[0] = 4'hF;
    do_write(32'h40, 0, 2, 1, 9, -1);
    wbuf[0] = 32'h5;
    aw_issue(32'h40, 0, 2, 1, 10, -1);
    ar_issue(32'h40, 0, 2, 1, 11);
    w_beats(32'h40, 0, 2, 1, -1);
    r_wait();
    b_wait();
    do_read(32'h40, 0, 2, 1, 12);

    // Randomized bursts over a 64-word window, addresses aliased through upper bits.
    for (int i = 0; i < 64; i++) begin wbuf[i] = $urandom(); sbuf[i] = 4'hF; end
    do_write(32'h400, 63, 2, 1, 0, -1);
    for (int n = 0; n < 40; n++) begin
      int len   = $urandom_range(0, 15);
      int size  = $urandom_range(0, 2);
      int burst = $urandom_range(0, 3);
      int id    = $urandom_range(0, 15);
      logic [31:0] addr = ($urandom() & ~32'(MEM_WORDS * 4 - 1)) | (32'h400 + 32'($urandom_range(0, 'hBF)));
      rready_mode = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 0) begin
        int bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
        for (int i = 0; i <= len; i++) begin wbuf[i] = $urandom(); sbuf[i] = 4'($urandom_range(0, 15)); end
        do_write(addr, len, size, burst, id, bad);
      end else begin
        do_read(addr, len, size, burst, id);
      end
    end
    rready_mode = 0;

    // Reset during beat 2 of a read burst.
    base = r_pops;
    ar_issue(32'h400, 5, 2, 1, 13);
    for (int t = 0; t < 100 && r_pops < base + 2; t++) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 0);
    check("mid_rst_rlast", 32'(rlast), 0);
    check("mid_rst_arready", 32'(arready), 0);
    rq.delete();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("rel_arready", 32'(arready), 1);
    @(posedge clk); #1;
    do_read(32'h200, 0, 2, 1, 14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
